// File: rtl/msg_stream_arbiter_pkg.sv
// Shared types and sizing helpers for the message stream arbiter.
package msg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Beats needed to carry the largest legal message.
    function automatic int max_beats(input int msg_bytes, input int data_bytes);
        return (msg_bytes + data_bytes - 1) / data_bytes;
    endfunction

    // Width of a source index.
    function automatic int src_idx_w(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

    // Beat counter width: must hold MAX_BEATS without wrapping.
    function automatic int cnt_w(input int beats);
        return $clog2(beats + 1);
    endfunction

endpackage

// File: rtl/msg_stream_arbiter_if.sv
// Source-side and parser-side AXI-Stream bundle around the arbiter.
// Handshake: a beat moves on a channel only in a cycle where both its
// tvalid and tready are high; payload (tdata/tkeep/tlast/tuser) must stay
// stable while tvalid is high and tready is low.
interface msg_stream_arbiter_if #(
    parameter int NUM_SRC     = 4,
    parameter int DATA_BYTES  = 8,
    parameter int TKEEP_WIDTH = 8
);
    import msg_arb_pkg::*;

    localparam int DW    = 8 * DATA_BYTES;
    localparam int IDX_W = src_idx_w(NUM_SRC);

    logic [NUM_SRC-1:0]             s_tvalid;
    logic [NUM_SRC-1:0]             s_tready;
    logic [NUM_SRC-1:0]             s_tlast;
    logic [NUM_SRC-1:0]             s_tuser;
    logic [NUM_SRC*DW-1:0]          s_tdata;
    logic [NUM_SRC*TKEEP_WIDTH-1:0] s_tkeep;

    logic                   m_tvalid;
    logic                   m_tready;
    logic                   m_tlast;
    logic                   m_tuser;
    logic [DW-1:0]          m_tdata;
    logic [TKEEP_WIDTH-1:0] m_tkeep;
    logic [IDX_W-1:0]       m_tid;

    // Arbiter side.
    modport slave (
        input  s_tvalid, s_tlast, s_tuser, s_tdata, s_tkeep, m_tready,
        output s_tready, m_tvalid, m_tlast, m_tuser, m_tdata, m_tkeep, m_tid
    );

    // Environment side: drives the sources and the parser ready.
    modport master (
        output s_tvalid, s_tlast, s_tuser, s_tdata, s_tkeep, m_tready,
        input  s_tready, m_tvalid, m_tlast, m_tuser, m_tdata, m_tkeep, m_tid
    );

endinterface

// File: rtl/msg_stream_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after i_last_gnt.
module rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_gnt,
    output logic               o_any,
    output logic [IDX_W-1:0]   o_idx
);

    // Doubled request vector so the scan from last_gnt+1 never wraps.
    logic [2*NUM_SRC-1:0] w_dbl;
    assign w_dbl = {i_req, i_req};

    // Scan downward so the closest requester after last_gnt wins.
    always_comb begin
        o_any = |i_req;
        o_idx = '0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            if (w_dbl[int'(i_last_gnt) + i]) begin
                o_idx = IDX_W'((int'(i_last_gnt) + i) % NUM_SRC);
            end
        end
    end

endmodule

// File: rtl/msg_stream_arbiter.sv
// Packet-atomic round-robin arbiter feeding msg_parser; truncates and
// drains packets longer than MAX_MSG_BYTES.
module msg_stream_arbiter
    import msg_arb_pkg::*;
#(
    parameter int NUM_SRC       = 4,
    parameter int DATA_BYTES    = 8,
    parameter int TKEEP_WIDTH   = 8,
    parameter int MAX_MSG_BYTES = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    msg_stream_arbiter_if.slave  bus,
    output logic                 trunc_pulse,
    output state_t               o_dbg_state
);

    localparam int DW        = 8 * DATA_BYTES;
    localparam int MAX_BEATS = max_beats(MAX_MSG_BYTES, DATA_BYTES);
    localparam int IDX_W     = src_idx_w(NUM_SRC);
    localparam int CNT_W     = cnt_w(MAX_BEATS);

    state_t             r_state;
    logic [IDX_W-1:0]   r_gnt;
    logic [IDX_W-1:0]   r_last_gnt;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic               r_trunc_pulse;

    state_t             w_next_state;
    logic               w_any;
    logic [IDX_W-1:0]   w_pick;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic               w_sel_user;
    logic               w_at_limit;
    logic               w_accept;
    logic               w_pkt_end;
    logic               w_trunc;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req      (bus.s_tvalid),
        .i_last_gnt (r_last_gnt),
        .o_any      (w_any),
        .o_idx      (w_pick)
    );

    assign w_sel_valid = bus.s_tvalid[r_gnt];
    assign w_sel_last  = bus.s_tlast[r_gnt];
    assign w_sel_user  = bus.s_tuser[r_gnt];
    assign w_at_limit  = (r_beat_cnt == CNT_W'(MAX_BEATS - 1));

    assign bus.m_tdata = bus.s_tdata[int'(r_gnt) * DW +: DW];
    assign bus.m_tkeep = bus.s_tkeep[int'(r_gnt) * TKEEP_WIDTH +: TKEEP_WIDTH];
    assign bus.m_tid   = r_gnt;
    assign trunc_pulse = r_trunc_pulse;
    assign o_dbg_state = r_state;

    // Next state, per-source ready and forwarded handshake/sideband.
    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_pkt_end     = 1'b0;
        w_trunc       = 1'b0;
        bus.s_tready  = '0;
        bus.m_tvalid  = 1'b0;
        bus.m_tlast   = 1'b0;
        bus.m_tuser   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) w_next_state = BUSY;
            end
            BUSY: begin
                bus.m_tvalid        = w_sel_valid;
                bus.s_tready[r_gnt] = bus.m_tready;
                // A source tlast on the limit beat is a legal end, not a cut.
                bus.m_tlast = w_sel_valid & (w_sel_last | w_at_limit);
                bus.m_tuser = w_sel_valid & (w_sel_last ? w_sel_user : w_at_limit);
                w_accept    = w_sel_valid & bus.m_tready;
                if (w_accept && w_sel_last) begin
                    w_pkt_end    = 1'b1;
                    w_next_state = IDLE;
                end else if (w_accept && w_at_limit) begin
                    w_trunc      = 1'b1;
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                bus.s_tready[r_gnt] = 1'b1;
                if (w_sel_valid && w_sel_last) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // FSM state register and the one-cycle truncation flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_trunc_pulse <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_trunc_pulse <= w_trunc;
        end
    end

    // Grant, fairness pointer and beat counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt      <= '0;
            r_last_gnt <= IDX_W'(NUM_SRC - 1);
            r_beat_cnt <= '0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_gnt      <= w_pick;
                r_beat_cnt <= '0;
            end
            if (w_accept) r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            if (w_pkt_end || w_trunc) r_last_gnt <= r_gnt;
        end
    end

endmodule
